// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port write scheduler: FSM states,
// port identifiers and bus widths.
package gpio_pkg;

  localparam int unsigned GPIO_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/gpio_port_sched_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered record of
// the last port granted (reset to B so that A wins the first tie).
module rr_arb2
  import gpio_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic upd_i,
  output logic gnt_valid_c,
  output logic gnt_port_c
);

  logic last_grant_q;
  logic last_grant_d;

  // On a tie, the port that was not served last goes first.
  always_comb begin
    gnt_valid_c = req_a_i | req_b_i;
    gnt_port_c  = PORT_A;
    if (req_a_i && req_b_i) begin
      gnt_port_c = ~last_grant_q;
    end else if (req_b_i) begin
      gnt_port_c = PORT_B;
    end
    last_grant_d = last_grant_q;
    if (upd_i && gnt_valid_c) begin
      last_grant_d = gnt_port_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/gpio_port_sched.sv
// Time-multiplexed write scheduler for the shared GPIO demux bus: arbitrates
// ports A/B, then sequences setup, a one-cycle latch strobe, hold and ack.
module gpio_port_sched
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = GPIO_W,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic [WIDTH-1:0] gpio_out,
  output logic             sel,
  output logic             strobe_a,
  output logic             strobe_b,
  output logic             busy
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   gpio_q, gpio_d;
  logic               sel_q, sel_d;
  logic               strobe_a_q, strobe_a_d;
  logic               strobe_b_q, strobe_b_d;
  logic               ack_a_q, ack_a_d;
  logic               ack_b_q, ack_b_d;
  logic               busy_q, busy_d;
  logic               grant;
  logic               gnt_valid;
  logic               gnt_port;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .upd_i       (grant),
    .gnt_valid_c (gnt_valid),
    .gnt_port_c  (gnt_port)
  );

  // Next state; outputs are derived from the next state so they register
  // into the same cycle the FSM enters the corresponding phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gpio_d  = gpio_q;
    sel_d   = sel_q;
    grant   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gpio_d = '0;
        if (en && gnt_valid) begin
          grant   = 1'b1;
          state_d = ST_SETUP;
          gpio_d  = (gnt_port == PORT_B) ? data_b : data_a;
          sel_d   = gnt_port;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        cnt_d   = HOLD_LD;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          gpio_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gpio_d  = '0;
      end
    endcase

    strobe_a_d = (state_d == ST_STROBE) && (sel_d == PORT_A);
    strobe_b_d = (state_d == ST_STROBE) && (sel_d == PORT_B);
    ack_a_d    = (state_d == ST_HOLD) && (cnt_d == '0) && (sel_d == PORT_A);
    ack_b_d    = (state_d == ST_HOLD) && (cnt_d == '0) && (sel_d == PORT_B);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gpio_q     <= '0;
      sel_q      <= PORT_A;
      strobe_a_q <= 1'b0;
      strobe_b_q <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gpio_q     <= gpio_d;
      sel_q      <= sel_d;
      strobe_a_q <= strobe_a_d;
      strobe_b_q <= strobe_b_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      busy_q     <= busy_d;
    end
  end

  assign gpio_out = gpio_q;
  assign sel      = sel_q;
  assign strobe_a = strobe_a_q;
  assign strobe_b = strobe_b_q;
  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_gpio_port_sched.sv
// Directed bench for gpio_port_sched: default timing plus SETUP/HOLD = 1/1
// and 15/15 instances for the timing sweep.
module tb_gpio_port_sched;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, sel, strobe_a, strobe_b, busy;
  logic [7:0] gpio_out;

  logic       s1_req, s15_req;
  logic       s1_ack_a, s1_ack_b, s1_sel, s1_stb_a, s1_stb_b, s1_busy;
  logic       s15_ack_a, s15_ack_b, s15_sel, s15_stb_a, s15_stb_b, s15_busy;
  logic [7:0] s1_gpio, s15_gpio;

  int n_pass = 0;
  int n_total = 0;

  gpio_port_sched #(.WIDTH(8), .SETUP_CYC(2), .HOLD_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .gpio_out(gpio_out), .sel(sel),
    .strobe_a(strobe_a), .strobe_b(strobe_b), .busy(busy)
  );

  gpio_port_sched #(.WIDTH(8), .SETUP_CYC(1), .HOLD_CYC(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .req_a(s1_req), .data_a(8'h81), .ack_a(s1_ack_a),
    .req_b(1'b0), .data_b(8'h00), .ack_b(s1_ack_b),
    .gpio_out(s1_gpio), .sel(s1_sel),
    .strobe_a(s1_stb_a), .strobe_b(s1_stb_b), .busy(s1_busy)
  );

  gpio_port_sched #(.WIDTH(8), .SETUP_CYC(15), .HOLD_CYC(15)) u_s15 (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .req_a(s15_req), .data_a(8'hF1), .ack_a(s15_ack_a),
    .req_b(1'b0), .data_b(8'h00), .ack_b(s15_ack_b),
    .gpio_out(s15_gpio), .sel(s15_sel),
    .strobe_a(s15_stb_a), .strobe_b(s15_stb_b), .busy(s15_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ack1, ack15, stb1, stb15, stbc1, stbc15, ovl;

    rst_n = 1'b0; en = 1'b1;
    req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
    s1_req = 1'b0; s15_req = 1'b0;

    #3;
    chk("rst_gpio", gpio_out, 0);
    chk("rst_sel", sel, 0);
    chk("rst_stb_a", strobe_a, 0);
    chk("rst_stb_b", strobe_b, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_busy", busy, 0);

    // Single request on A: cycle 0 is the IDLE cycle that samples req_a.
    tick();
    rst_n = 1'b1;
    req_a = 1'b1; data_a = 8'hA5;
    tick();
    chk("t1_c1_sel", sel, 0);
    chk("t1_c1_gpio", gpio_out, 8'hA5);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_stb_a", strobe_a, 0);
    chk("t1_c1_stb_b", strobe_b, 0);
    tick();
    chk("t1_c2_busy", busy, 1);
    chk("t1_c2_stb_a", strobe_a, 0);
    chk("t1_c2_gpio", gpio_out, 8'hA5);
    tick();
    chk("t1_c3_stb_a", strobe_a, 1);
    chk("t1_c3_stb_b", strobe_b, 0);
    chk("t1_c3_ack_a", ack_a, 0);
    chk("t1_c3_busy", busy, 1);
    tick();
    chk("t1_c4_ack_a", ack_a, 1);
    chk("t1_c4_ack_b", ack_b, 0);
    chk("t1_c4_stb_a", strobe_a, 0);
    chk("t1_c4_stb_b", strobe_b, 0);
    chk("t1_c4_busy", busy, 1);
    req_a = 1'b0;
    tick();
    chk("t1_c5_busy", busy, 0);
    chk("t1_c5_ack_a", ack_a, 0);
    chk("t1_c5_gpio", gpio_out, 0);

    // Reset so last_grant is B again, then hold both requests: A, B, A, B.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req_a = 1'b1; data_a = 8'h11;
    req_b = 1'b1; data_b = 8'h22;
    for (int k = 0; k < 4; k++) begin
      logic       ep;
      logic [7:0] ed;
      ep = (k % 2 == 1);
      ed = ep ? 8'h22 : 8'h11;
      tick();
      chk($sformatf("t2_k%0d_sel", k), sel, ep);
      chk($sformatf("t2_k%0d_gpio", k), gpio_out, ed);
      tick();
      tick();
      chk($sformatf("t2_k%0d_stb_a", k), strobe_a, !ep);
      chk($sformatf("t2_k%0d_stb_b", k), strobe_b, ep);
      tick();
      chk($sformatf("t2_k%0d_ack_a", k), ack_a, !ep);
      chk($sformatf("t2_k%0d_ack_b", k), ack_b, ep);
      if (k == 3) begin
        req_a = 1'b0; req_b = 1'b0;
      end
      tick();
      chk($sformatf("t2_k%0d_idle", k), busy, 0);
    end

    // Data change on B after grant must not reach the bus.
    req_b = 1'b1; data_b = 8'h3C;
    tick();
    chk("t3_c1_sel", sel, 1);
    chk("t3_c1_gpio", gpio_out, 8'h3C);
    tick();
    data_b = 8'hFF;
    tick();
    chk("t3_c3_stb_b", strobe_b, 1);
    chk("t3_c3_gpio", gpio_out, 8'h3C);
    tick();
    chk("t3_c4_ack_b", ack_b, 1);
    chk("t3_c4_gpio", gpio_out, 8'h3C);
    req_b = 1'b0;
    tick();
    chk("t3_c5_busy", busy, 0);

    // en low blocks grants; dropping en mid-transaction does not abort.
    en = 1'b0; req_a = 1'b1; data_a = 8'hC3;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t4_blk%0d_busy", c), busy, 0);
      chk($sformatf("t4_blk%0d_stb", c), strobe_a, 0);
    end
    en = 1'b1;
    tick();
    chk("t4_c1_busy", busy, 1);
    chk("t4_c1_gpio", gpio_out, 8'hC3);
    en = 1'b0;
    tick();
    tick();
    chk("t4_c3_stb_a", strobe_a, 1);
    tick();
    chk("t4_c4_ack_a", ack_a, 1);
    req_a = 1'b0; en = 1'b1;
    tick();
    chk("t4_c5_busy", busy, 0);

    // Asynchronous reset while strobing: everything clears, no ack.
    req_a = 1'b1; data_a = 8'h5A;
    tick();
    tick();
    tick();
    chk("t5_pre_stb_a", strobe_a, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_stb_a", strobe_a, 0);
    chk("t5_rst_sel", sel, 0);
    chk("t5_rst_gpio", gpio_out, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ack_a", ack_a, 0);
    tick();
    chk("t5_held_ack_a", ack_a, 0);
    rst_n = 1'b1;
    tick();
    chk("t5_new_busy", busy, 1);
    chk("t5_new_gpio", gpio_out, 8'h5A);
    tick();
    tick();
    chk("t5_new_stb_a", strobe_a, 1);
    tick();
    chk("t5_new_ack_a", ack_a, 1);
    req_a = 1'b0;
    tick();

    // Timing sweep on the 1/1 and 15/15 instances, bounded at 40 cycles.
    ack1 = -1; ack15 = -1; stb1 = 0; stb15 = 0; stbc1 = -1; stbc15 = -1; ovl = 0;
    s1_req = 1'b1; s15_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (s1_stb_a) begin stb1++; stbc1 = c; end
      if (s15_stb_a) begin stb15++; stbc15 = c; end
      if ((s1_stb_a && s1_ack_a) || (s15_stb_a && s15_ack_a)) ovl++;
      if (s1_ack_a && ack1 < 0) begin ack1 = c; s1_req = 1'b0; end
      if (s15_ack_a && ack15 < 0) begin ack15 = c; s15_req = 1'b0; end
    end
    chk("sw1_ack_cyc", ack1, 3);
    chk("sw1_stb_cnt", stb1, 1);
    chk("sw1_stb_cyc", stbc1, 2);
    chk("sw15_ack_cyc", ack15, 31);
    chk("sw15_stb_cnt", stb15, 1);
    chk("sw15_stb_cyc", stbc15, 16);
    chk("sw_stb_ack_overlap", ovl, 0);
    chk("sw1_idle_after", s1_busy, 0);
    chk("sw15_idle_after", s15_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
